data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Multi-cycle responder for the MEM-stage data-memory request interface: enable, RW, address, store data, size.
- Replaces the zero-latency data RAM with a byte-addressed, big-endian memory that inserts programmable wait states.
- Returns a registered load result with a one-cycle Ready pulse.
- Drives a combinational Busy stall request to the hazard unit, which freezes PC, IF/ID, ID/EX and EX/MEM while Busy=1.

Parameters:
WAIT_STATES, 2, extra cycles between request acceptance and response (0..15)
ADDR_BITS, 8, byte-address width; memory depth = 2**ADDR_BITS bytes

Ports:
CLK  input  1  clock, rising edge
CLR  input  1  asynchronous active-low reset
Mem_Enable  input  1  request valid; held stable by the pipeline until Ready
Mem_RW  input  1  0=load, 1=store
Mem_Size  input  2  00=byte, 01=halfword, 10=word, 11=word
Mem_Addr  input  32  byte address; bits above ADDR_BITS-1 ignored
Mem_Wdata  input  32  store data; byte in [7:0], halfword in [15:0]
Mem_Rdata  output  32  load result, zero-extended
Mem_Ready  output  1  one-cycle completion pulse
Mem_Busy  output  1  stall request to the hazard unit
Mem_Error  output  1  misaligned access flag (Optional Feature only)

Behaviour:
- Reset (CLR=0, async):
  - state=IDLE, wait counter=0, Mem_Rdata=0, Mem_Ready=0, Mem_Error=0.
  - Memory array is NOT cleared; benches precharge it hierarchically through Mem[].
- FSM states: IDLE, WAIT, RESP.
  - IDLE & Mem_Enable=1: latch RW/Size/Addr/Wdata, counter=0. Go to RESP if WAIT_STATES==0, otherwise go to WAIT.
  - WAIT: counter increments each cycle. Go to RESP when counter==WAIT_STATES-1.
  - WAIT & Mem_Enable=0: abort, return to IDLE, no write, no Ready (squash case).
  - RESP: Mem_Ready=1 for exactly this cycle, then go to IDLE unconditionally.
- Latency and throughput:
  - Ready is asserted WAIT_STATES+1 cycles after the acceptance edge.
  - Back-to-back requests are spaced WAIT_STATES+2 cycles apart, because IDLE always lasts at least one cycle.
- Mem_Busy = Mem_Enable & (state != RESP), combinational.
  - With Mem_Enable=0, Busy=0 in every state.
- Store commit:
  - The memory write happens on the RESP entry edge, using the latched fields.
  - Big-endian layout: word writes Mem[a]=W[31:24] .. Mem[a+3]=W[7:0]; halfword writes Mem[a]=W[15:8], Mem[a+1]=W[7:0]; byte writes Mem[a]=W[7:0].
- Load:
  - Mem_Rdata is registered on the RESP entry edge with the same big-endian assembly, zero-extended.
  - Mem_Rdata holds its value until the next load completes.
  - Stores leave Mem_Rdata unchanged.
- Address arithmetic is modulo 2**ADDR_BITS, so a byte offset past the top wraps to 0.
- Alignment without the Optional Feature: the low address bits are forced to zero (halfword clears [0], word clears [1:0]).
- Reset mid-operation aborts the request. An uncommitted store never writes.
- Mem_Rdata and Mem_Ready change only on clock or reset edges.

Optional Feature:
MEM_ALIGN_CHECK_EN
- Defined:
  - Halfword with Addr[0]=1, or word with Addr[1:0]!=0, is misaligned.
  - Misaligned request still follows the normal FSM timing.
  - In RESP: Mem_Error=1 together with Mem_Ready. The store is suppressed; a load returns Mem_Rdata=0.
  - Mem_Error is cleared on the next accepted request or on reset.
- Undefined:
  - Low bits are forced aligned as in Behaviour.
  - Mem_Error is tied to 0.

Test Plan:
- Word store, then load, WAIT_STATES=2:
  - Store 0xDEADBEEF to addr 0x10 -> Ready 3 cycles after acceptance; Mem[0x10..0x13]=DE,AD,BE,EF; Busy=1 for 3 cycles.
  - Then load word 0x10 -> Mem_Rdata=0xDEADBEEF with Ready.
- Sub-word access:
  - Byte store 0x000000A5 to 0x21 -> only Mem[0x21] changes.
  - Halfword load from 0x20 with Mem[0x20]=0x12 -> Mem_Rdata=0x000012A5.
- Squash: drop Mem_Enable during WAIT on a store of 0x11223344 to 0x30 -> no Ready, Mem[0x30..0x33] unchanged, FSM back in IDLE next cycle.
- Async reset: pull CLR low mid-WAIT between clock edges -> Ready=0, Rdata=0 immediately; store not committed; memory contents preserved.
- Zero wait states: WAIT_STATES=0, load word 0x04 -> Ready on the first edge after acceptance; second request accepted 2 cycles after the first.
- Alignment (MEM_ALIGN_CHECK_EN):
  - Word store to 0x06 -> Error=1 with Ready, memory unchanged.
  - Without the macro, the same request writes Mem[0x04..0x07] and Error=0.

Source files
------------

// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if: MEM-stage data-memory request/response bundle.
// The master (pipeline) holds Mem_Enable and the request fields stable until Mem_Ready.
interface data_mem_responder_if;
    logic        Mem_Enable;
    logic        Mem_RW;
    logic [1:0]  Mem_Size;
    logic [31:0] Mem_Addr;
    logic [31:0] Mem_Wdata;
    logic [31:0] Mem_Rdata;
    logic        Mem_Ready;
    logic        Mem_Busy;
    logic        Mem_Error;

    modport master (
        output Mem_Enable, Mem_RW, Mem_Size, Mem_Addr, Mem_Wdata,
        input  Mem_Rdata, Mem_Ready, Mem_Busy, Mem_Error
    );

    modport slave (
        input  Mem_Enable, Mem_RW, Mem_Size, Mem_Addr, Mem_Wdata,
        output Mem_Rdata, Mem_Ready, Mem_Busy, Mem_Error
    );
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder: big-endian byte memory with programmable wait states.
// Define MEM_ALIGN_CHECK_EN to flag misaligned accesses instead of aligning them.
module data_mem_responder #(
    parameter int WAIT_STATES = 2,
    parameter int ADDR_BITS   = 8
) (
    input logic                 CLK,
    input logic                 CLR,
    data_mem_responder_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_BITS;
    localparam logic [3:0] LAST_CNT = 4'(WAIT_STATES - 1);
    localparam logic [ADDR_BITS-1:0] ONE = ADDR_BITS'(1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    logic [7:0] Mem [DEPTH];

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  rw_q, rw_d;
    logic [1:0]            size_q, size_d;
    logic [ADDR_BITS-1:0]  addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  ready_q, ready_d;

    logic                  accept;
    logic                  commit;
    logic                  mis;
    logic                  we;
    logic                  eff_rw;
    logic [1:0]            eff_size;
    logic [ADDR_BITS-1:0]  eff_addr;
    logic [31:0]           eff_wdata;
    logic [ADDR_BITS-1:0]  a0, a1, a2, a3;
    logic [31:0]           load_val;
    logic                  unused_addr_hi;

    assign unused_addr_hi = ^bus.Mem_Addr[31:ADDR_BITS];

    assign accept = (state_q == IDLE) && bus.Mem_Enable;

    // With no wait states the commit edge is the acceptance edge,
    // so the live request fields are used before they are latched.
    assign eff_rw    = accept ? bus.Mem_RW : rw_q;
    assign eff_size  = accept ? bus.Mem_Size : size_q;
    assign eff_addr  = accept ? bus.Mem_Addr[ADDR_BITS-1:0] : addr_q;
    assign eff_wdata = accept ? bus.Mem_Wdata : wdata_q;

`ifdef MEM_ALIGN_CHECK_EN
    assign mis = ((eff_size == 2'b01) && eff_addr[0]) ||
                 (eff_size[1] && (eff_addr[1:0] != 2'b00));
    assign a0  = eff_addr;
`else
    assign mis = 1'b0;
    always_comb begin
        a0 = eff_addr;
        if (eff_size == 2'b01) begin
            a0[0] = 1'b0;
        end else if (eff_size[1]) begin
            a0[1:0] = 2'b00;
        end
    end
`endif

    assign a1 = a0 + ONE;
    assign a2 = a1 + ONE;
    assign a3 = a2 + ONE;

    always_comb begin
        case (eff_size)
            2'b00:   load_val = {24'h0, Mem[a0]};
            2'b01:   load_val = {16'h0, Mem[a0], Mem[a1]};
            default: load_val = {Mem[a0], Mem[a1], Mem[a2], Mem[a3]};
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rw_d    = rw_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ready_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.Mem_Enable) begin
                    rw_d    = bus.Mem_RW;
                    size_d  = bus.Mem_Size;
                    addr_d  = bus.Mem_Addr[ADDR_BITS-1:0];
                    wdata_d = bus.Mem_Wdata;
                    cnt_d   = 4'd0;
                    state_d = (WAIT_STATES == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (!bus.Mem_Enable) begin
                    state_d = IDLE;
                end else if (cnt_q == LAST_CNT) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (state_d == RESP) begin
            ready_d = 1'b1;
            if (!eff_rw) begin
                rdata_d = mis ? 32'h0 : load_val;
            end
        end
    end

    assign commit = (state_d == RESP);
    assign we     = commit && eff_rw && !mis;

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rw_q    <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rw_q    <= rw_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
        end
    end

    // Contents survive reset; only the clock edge that enters RESP writes.
    always_ff @(posedge CLK) begin
        if (we) begin
            case (eff_size)
                2'b00: Mem[a0] <= eff_wdata[7:0];
                2'b01: begin
                    Mem[a0] <= eff_wdata[15:8];
                    Mem[a1] <= eff_wdata[7:0];
                end
                default: begin
                    Mem[a0] <= eff_wdata[31:24];
                    Mem[a1] <= eff_wdata[23:16];
                    Mem[a2] <= eff_wdata[15:8];
                    Mem[a3] <= eff_wdata[7:0];
                end
            endcase
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    logic error_q, error_d;

    always_comb begin
        error_d = error_q;
        if (accept) begin
            error_d = 1'b0;
        end
        if (commit) begin
            error_d = mis;
        end
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            error_q <= 1'b0;
        end else begin
            error_q <= error_d;
        end
    end

    assign bus.Mem_Error = error_q;
`else
    assign bus.Mem_Error = 1'b0;
`endif

    assign bus.Mem_Rdata = rdata_q;
    assign bus.Mem_Ready = ready_q;
    assign bus.Mem_Busy  = bus.Mem_Enable && (state_q != RESP);
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: random and directed checks of two responders
// (2 and 0 wait states) against a transaction-level memory model.
module tb_data_mem_responder;
    logic clk = 1'b0;
    logic clr = 1'b0;
    always #5 clk = ~clk;

    logic        en  [2];
    logic        rw  [2];
    logic [1:0]  sz  [2];
    logic [31:0] ad  [2];
    logic [31:0] wd  [2];
    logic        rdy [2];
    logic        bsy [2];
    logic        er  [2];
    logic [31:0] rd  [2];

    data_mem_responder_if b0 ();
    data_mem_responder_if b1 ();

    assign b0.Mem_Enable = en[0];
    assign b0.Mem_RW     = rw[0];
    assign b0.Mem_Size   = sz[0];
    assign b0.Mem_Addr   = ad[0];
    assign b0.Mem_Wdata  = wd[0];
    assign b1.Mem_Enable = en[1];
    assign b1.Mem_RW     = rw[1];
    assign b1.Mem_Size   = sz[1];
    assign b1.Mem_Addr   = ad[1];
    assign b1.Mem_Wdata  = wd[1];
    assign rdy[0] = b0.Mem_Ready;
    assign bsy[0] = b0.Mem_Busy;
    assign er[0]  = b0.Mem_Error;
    assign rd[0]  = b0.Mem_Rdata;
    assign rdy[1] = b1.Mem_Ready;
    assign bsy[1] = b1.Mem_Busy;
    assign er[1]  = b1.Mem_Error;
    assign rd[1]  = b1.Mem_Rdata;

    data_mem_responder #(.WAIT_STATES(2), .ADDR_BITS(8)) dut (
        .CLK(clk), .CLR(clr), .bus(b0)
    );
    data_mem_responder #(.WAIT_STATES(0), .ADDR_BITS(8)) dut0 (
        .CLK(clk), .CLR(clr), .bus(b1)
    );

    int tests = 0;
    int fails = 0;
    int ws [2] = '{2, 0};
    int edges = 0;

    bit          inflight [2];
    bit          cool     [2];
    int          done_e   [2];
    bit          m_rw     [2];
    logic [1:0]  m_sz     [2];
    logic [31:0] m_ad     [2];
    logic [31:0] m_wd     [2];
    logic [7:0]  ref_mem  [2][256];
    bit          x_ready  [2];
    bit          x_err    [2];
    logic [31:0] x_rdata  [2];

    function automatic logic [7:0] memrd(input int k, input int a);
        return (k == 0) ? dut.Mem[a] : dut0.Mem[a];
    endfunction

    task automatic chk(input string nm, input int k,
                       input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s[%0d]: got %h expected %h at t=%0t",
                     nm, k, act, exp, $time);
        end
    endtask

    task automatic complete(input int k);
        int a;
        int nb;
        bit mis;
        logic [31:0] v;
        inflight[k] = 1'b0;
        cool[k]     = 1'b1;
        x_ready[k]  = 1'b1;
        a  = int'(m_ad[k][7:0]);
        nb = (m_sz[k] == 2'd0) ? 1 : (m_sz[k] == 2'd1) ? 2 : 4;
        mis = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        mis = (a % nb) != 0;
`else
        a = a - (a % nb);
`endif
        x_err[k] = mis;
        if (m_rw[k]) begin
            if (!mis)
                for (int i = 0; i < nb; i++)
                    ref_mem[k][8'(a + i)] = 8'(m_wd[k] >> (8 * (nb - 1 - i)));
        end else begin
            v = 32'h0;
            if (!mis)
                for (int i = 0; i < nb; i++)
                    v = (v << 8) | {24'h0, ref_mem[k][8'(a + i)]};
            x_rdata[k] = v;
        end
    endtask

    task automatic step(input int k);
        x_ready[k] = 1'b0;
        if (inflight[k]) begin
            if (!en[k]) inflight[k] = 1'b0;
            else if (edges == done_e[k]) complete(k);
        end else if (cool[k]) begin
            cool[k] = 1'b0;
        end else if (en[k]) begin
            m_rw[k]   = rw[k];
            m_sz[k]   = sz[k];
            m_ad[k]   = ad[k];
            m_wd[k]   = wd[k];
            x_err[k]  = 1'b0;
            done_e[k] = edges + ws[k];
            if (ws[k] == 0) complete(k);
            else inflight[k] = 1'b1;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge clr);
            if (!clr) begin
                for (int k = 0; k < 2; k++) begin
                    inflight[k] = 1'b0;
                    cool[k]     = 1'b0;
                    x_ready[k]  = 1'b0;
                    x_err[k]    = 1'b0;
                    x_rdata[k]  = 32'h0;
                end
            end else begin
                edges++;
                for (int k = 0; k < 2; k++) step(k);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (clr) begin
                for (int k = 0; k < 2; k++) begin
                    chk("ready", k, 32'(rdy[k]), 32'(x_ready[k]));
                    chk("rdata", k, rd[k], x_rdata[k]);
                    chk("busy", k, 32'(bsy[k]), 32'(en[k] && !x_ready[k]));
                    chk("error", k, 32'(er[k]), 32'(x_err[k]));
                end
            end
        end
    end

    task automatic xact(input int k, input bit r, input logic [1:0] s,
                        input logic [31:0] a, input logic [31:0] w,
                        output int lat, output int bc, output int rc);
        bit got;
        got = 1'b0;
        rw[k] = r;
        sz[k] = s;
        ad[k] = a;
        wd[k] = w;
        en[k] = 1'b1;
        lat = 0;
        bc  = 0;
        rc  = -1;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (bsy[k]) bc++;
            if (rdy[k]) begin
                got = 1'b1;
                rc  = edges;
            end
        end
        tests++;
        if (!got) begin
            fails++;
            $display("FAIL timeout[%0d]: no Ready after %0d cycles, required within %0d",
                     k, lat, ws[k] + 2);
        end
        @(posedge clk);
        #2;
        en[k] = 1'b0;
    endtask

    task automatic squash(input int k, input int hold,
                          input logic [31:0] a, input logic [31:0] w,
                          output int nr);
        rw[k] = 1'b1;
        sz[k] = 2'b10;
        ad[k] = a;
        wd[k] = w;
        en[k] = 1'b1;
        nr = 0;
        repeat (hold) begin
            @(negedge clk);
            if (rdy[k]) nr++;
            @(posedge clk);
        end
        #2;
        en[k] = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (rdy[k]) nr++;
        end
        @(posedge clk);
        #2;
    endtask

    task automatic pre(input int k, input int a, input logic [7:0] v);
        if (k == 0) dut.Mem[a] = v;
        else dut0.Mem[a] = v;
        ref_mem[k][a] = v;
    endtask

    initial begin
        int lat, bc, rc, rc2, nr, r, bad;
        for (int k = 0; k < 2; k++) begin
            en[k] = 1'b0;
            rw[k] = 1'b0;
            sz[k] = 2'b00;
            ad[k] = 32'h0;
            wd[k] = 32'h0;
            x_rdata[k] = 32'h0;
            for (int i = 0; i < 256; i++) pre(k, i, 8'($urandom));
        end
        pre(0, 8'h20, 8'h12);
        pre(0, 8'h21, 8'h34);
        pre(0, 8'h22, 8'h77);
        for (int i = 0; i < 4; i++) begin
            pre(0, 8'h30 + i, 8'hA0 + 8'(i));
            pre(0, 8'h40 + i, 8'hB0 + 8'(i));
            pre(0, 8'h04 + i, 8'hC0 + 8'(i));
            pre(1, 8'h04 + i, 8'h01 + 8'(i));
        end

        #23 clr = 1'b1;
        @(posedge clk);
        #2;

        xact(0, 1'b1, 2'b10, 32'h10, 32'hDEADBEEF, lat, bc, rc);
        chk("st_lat", 0, 32'(lat), 32'd4);
        chk("st_busy", 0, 32'(bc), 32'd3);
        chk("st_mem", 0, {memrd(0, 16), memrd(0, 17), memrd(0, 18), memrd(0, 19)},
            32'hDEADBEEF);
        xact(0, 1'b0, 2'b10, 32'h10, 32'h0, lat, bc, rc2);
        chk("ld_word", 0, rd[0], 32'hDEADBEEF);
        chk("b2b_gap", 0, 32'(rc2 - rc), 32'd4);

        xact(0, 1'b1, 2'b00, 32'h21, 32'h000000A5, lat, bc, rc);
        chk("sb_mem", 0, {8'h0, memrd(0, 32), memrd(0, 33), memrd(0, 34)},
            32'h0012A577);
        xact(0, 1'b0, 2'b01, 32'h20, 32'h0, lat, bc, rc);
        chk("ld_half", 0, rd[0], 32'h000012A5);

        squash(0, 2, 32'h30, 32'h11223344, nr);
        chk("sq_ready", 0, 32'(nr), 32'd0);
        chk("sq_mem", 0, {memrd(0, 48), memrd(0, 49), memrd(0, 50), memrd(0, 51)},
            32'hA0A1A2A3);

        rw[0] = 1'b1;
        sz[0] = 2'b10;
        ad[0] = 32'h40;
        wd[0] = 32'h55667788;
        en[0] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #3 clr = 1'b0;
        #1;
        chk("rst_ready", 0, 32'(rdy[0]), 32'd0);
        chk("rst_rdata", 0, rd[0], 32'h0);
        en[0] = 1'b0;
        @(posedge clk);
        #3 clr = 1'b1;
        @(posedge clk);
        #2;
        chk("rst_mem", 0, {memrd(0, 64), memrd(0, 65), memrd(0, 66), memrd(0, 67)},
            32'hB0B1B2B3);

        xact(1, 1'b0, 2'b10, 32'h04, 32'h0, lat, bc, rc);
        chk("z_lat", 1, 32'(lat), 32'd2);
        chk("z_busy", 1, 32'(bc), 32'd1);
        chk("z_word", 1, rd[1], 32'h01020304);
        xact(1, 1'b0, 2'b00, 32'h07, 32'h0, lat, bc, rc2);
        chk("z_gap", 1, 32'(rc2 - rc), 32'd2);
        chk("z_byte", 1, rd[1], 32'h00000004);

        xact(0, 1'b1, 2'b10, 32'h06, 32'hCAFEF00D, lat, bc, rc);
`ifdef MEM_ALIGN_CHECK_EN
        chk("al_err", 0, 32'(er[0]), 32'd1);
        chk("al_mem", 0, {memrd(0, 4), memrd(0, 5), memrd(0, 6), memrd(0, 7)},
            32'hC0C1C2C3);
`else
        chk("al_err", 0, 32'(er[0]), 32'd0);
        chk("al_mem", 0, {memrd(0, 4), memrd(0, 5), memrd(0, 6), memrd(0, 7)},
            32'hCAFEF00D);
`endif

        for (int k = 0; k < 2; k++) begin
            for (int n = 0; n < 150; n++) begin
                r = $urandom_range(0, 9);
                if (k == 0 && r == 0)
                    squash(0, $urandom_range(1, 2), $urandom, $urandom, nr);
                else
                    xact(k, 1'($urandom), 2'($urandom), $urandom, $urandom,
                         lat, bc, rc);
                if ($urandom_range(0, 3) == 0) begin
                    repeat ($urandom_range(1, 3)) @(posedge clk);
                    #2;
                end
            end
        end

        for (int k = 0; k < 2; k++) begin
            bad = 0;
            for (int i = 0; i < 256; i++)
                if (memrd(k, i) !== ref_mem[k][i]) bad++;
            chk("mem_image", k, 32'(bad), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
